// File: rtl/cim_ctrl_pkg.sv
// Shared types and sizing helpers for the CIM input-buffer controller.
package cim_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CIM,
    LOAD,
    WAIT_FUNC,
    DONE
  } state_t;

  function automatic int unsigned cdiv(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Rows driven per tile: a full crossbar when the vector spans several tiles,
  // otherwise just the vector length.
  function automatic int unsigned rows_of(input int unsigned input_size,
                                          input int unsigned xbar_size);
    return (cdiv(input_size, xbar_size) > 1) ? xbar_size : input_size;
  endfunction

  function automatic int unsigned beats_of(input int unsigned input_size,
                                           input int unsigned xbar_size,
                                           input int unsigned lanes);
    return cdiv(rows_of(input_size, xbar_size), lanes);
  endfunction

endpackage

// File: rtl/cim_ibuf_lane_mux.sv
// Row select for one (tile, lane) write field, zeroing rows beyond the vector
// or beyond the latched active length.
module cim_ibuf_lane_mux #(
  parameter int unsigned DATATYPE_SIZE = 8,
  parameter int unsigned INPUT_SIZE    = 201,
  parameter int unsigned LEN_W         = 8
) (
  input  logic [31:0]                          row,
  input  logic [LEN_W-1:0]                     len,
  input  logic [INPUT_SIZE*DATATYPE_SIZE-1:0]  data,
  output logic [DATATYPE_SIZE-1:0]             elem
);

  localparam int unsigned IDX_W = $clog2(INPUT_SIZE * DATATYPE_SIZE);

  logic             valid;
  logic [31:0]      sel;
  logic [IDX_W-1:0] idx;

  // Select the element for this row, or zero when the row is masked.
  always_comb begin
    valid = (row < INPUT_SIZE) && (row < 32'(len));
    sel   = valid ? row : '0;
    idx   = IDX_W'(sel * DATATYPE_SIZE);
    elem  = valid ? data[idx +: DATATYPE_SIZE] : '0;
  end

endmodule

// File: rtl/cim_ibuf_ctrl.sv
// Input-buffer controller: streams the activation vector into the vertical CIM
// tile stack LANES rows per beat, then launches the compute.
// Optional stall counters are built when CIM_IBUF_PERF_CNT_EN is defined.
module cim_ibuf_ctrl
  import cim_ctrl_pkg::*;
#(
  parameter int unsigned DATATYPE_SIZE = 8,
  parameter int unsigned INPUT_SIZE    = 201,
  parameter int unsigned XBAR_SIZE     = 256,
  parameter int unsigned LANES         = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_start,
  input  logic [$clog2(INPUT_SIZE+1)-1:0]        i_len,
  input  logic [INPUT_SIZE*DATATYPE_SIZE-1:0]    i_data,
  input  logic                                   i_cim_busy,
  input  logic                                   i_func_busy,
  output logic                                   o_busy,
  output logic                                   o_cim_we,
  output logic [$clog2(XBAR_SIZE)-1:0]           o_cim_addr,
  output logic [cdiv(INPUT_SIZE, XBAR_SIZE)*LANES*DATATYPE_SIZE-1:0] o_data,
  output logic                                   o_cim_start,
  output logic                                   o_done
`ifdef CIM_IBUF_PERF_CNT_EN
  ,
  output logic [31:0]                            o_stall_cim_cnt,
  output logic [31:0]                            o_stall_func_cnt
`endif
);

  localparam int unsigned V_CIM_TILES = cdiv(INPUT_SIZE, XBAR_SIZE);
  localparam int unsigned BEATS       = beats_of(INPUT_SIZE, XBAR_SIZE, LANES);
  localparam int unsigned BEAT_W      = $clog2(BEATS + 1);
  localparam int unsigned ADDR_W      = $clog2(XBAR_SIZE);
  localparam int unsigned LEN_W       = $clog2(INPUT_SIZE + 1);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    len_eff;
  logic [ADDR_W-1:0]   addr_d;
  logic                start_acc;

  // Next-state, beat/length update and handshake-qualified strobes.
  // Write and launch strobes are qualified by the live busy inputs so a
  // stalled cycle never issues a write or a launch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    len_d       = len_q;
    start_acc   = 1'b0;
    len_eff     = (i_len == '0 || i_len > LEN_W'(INPUT_SIZE)) ? LEN_W'(INPUT_SIZE) : i_len;
    o_cim_we    = (state_q == LOAD) && !i_cim_busy;
    o_cim_start = (state_q == WAIT_FUNC) && !i_func_busy;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          start_acc = 1'b1;
          len_d     = len_eff;
          beat_d    = '0;
          state_d   = i_cim_busy ? WAIT_CIM : LOAD;
        end
      end
      WAIT_CIM: begin
        if (!i_cim_busy) state_d = LOAD;
      end
      LOAD: begin
        if (!i_cim_busy) begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = WAIT_FUNC;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      WAIT_FUNC: begin
        if (!i_func_busy) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    addr_d = ADDR_W'(32'(beat_d) * LANES);
  end

  // State, beat, length and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      len_q      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_cim_addr <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      o_busy     <= (state_d == WAIT_CIM) || (state_d == LOAD) || (state_d == WAIT_FUNC);
      o_done     <= (state_d == DONE);
      o_cim_addr <= addr_d;
    end
  end

  for (genvar t = 0; t < V_CIM_TILES; t++) begin : g_tile
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      cim_ibuf_lane_mux #(
        .DATATYPE_SIZE (DATATYPE_SIZE),
        .INPUT_SIZE    (INPUT_SIZE),
        .LEN_W         (LEN_W)
      ) u_mux (
        .row  (32'(t * XBAR_SIZE + l) + 32'(o_cim_addr)),
        .len  (len_q),
        .data (i_data),
        .elem (o_data[(t*LANES+l)*DATATYPE_SIZE +: DATATYPE_SIZE])
      );
    end
  end

`ifdef CIM_IBUF_PERF_CNT_EN
  // Saturating stall counters, cleared on reset and on every accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_stall_cim_cnt  <= '0;
      o_stall_func_cnt <= '0;
    end else if (start_acc) begin
      o_stall_cim_cnt  <= '0;
      o_stall_func_cnt <= '0;
    end else begin
      if (state_q == LOAD && i_cim_busy && o_stall_cim_cnt != '1)
        o_stall_cim_cnt <= o_stall_cim_cnt + 32'd1;
      if (state_q == WAIT_FUNC && i_func_busy && o_stall_func_cnt != '1)
        o_stall_func_cnt <= o_stall_func_cnt + 32'd1;
    end
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_cim_ibuf_ctrl.sv
// Bench for cim_ibuf_ctrl: three configurations (201/256/1, 201/256/4,
// 300/256/2) checked every cycle against a transaction-level model.
module tb_cim_ibuf_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int IS [3] = '{201, 201, 300};
  int LN [3] = '{1, 4, 2};
  localparam int XB = 256;

  logic       start_i [3];
  logic       cim_i   [3];
  logic       fb_i    [3];
  logic [8:0] len_i   [3];

  logic [201*8-1:0] d201;
  logic [300*8-1:0] d300;

  logic        busy_o [3];
  logic        we_o   [3];
  logic [7:0]  addr_o [3];
  logic        cs_o   [3];
  logic        done_o [3];
  logic [31:0] data_o [3];
  logic [7:0]  data0;
  logic [31:0] data1, data2;
  assign data_o[0] = {24'b0, data0};
  assign data_o[1] = data1;
  assign data_o[2] = data2;

  cim_ibuf_ctrl u_dut0 (
    .clk(clk), .rst(rst), .i_start(start_i[0]), .i_len(len_i[0][7:0]), .i_data(d201),
    .i_cim_busy(cim_i[0]), .i_func_busy(fb_i[0]), .o_busy(busy_o[0]), .o_cim_we(we_o[0]),
    .o_cim_addr(addr_o[0]), .o_data(data0), .o_cim_start(cs_o[0]), .o_done(done_o[0])
  );

  cim_ibuf_ctrl #(.LANES(4)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start_i[1]), .i_len(len_i[1][7:0]), .i_data(d201),
    .i_cim_busy(cim_i[1]), .i_func_busy(fb_i[1]), .o_busy(busy_o[1]), .o_cim_we(we_o[1]),
    .o_cim_addr(addr_o[1]), .o_data(data1), .o_cim_start(cs_o[1]), .o_done(done_o[1])
  );

  cim_ibuf_ctrl #(.INPUT_SIZE(300), .XBAR_SIZE(256), .LANES(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_start(start_i[2]), .i_len(len_i[2]), .i_data(d300),
    .i_cim_busy(cim_i[2]), .i_func_busy(fb_i[2]), .o_busy(busy_o[2]), .o_cim_we(we_o[2]),
    .o_cim_addr(addr_o[2]), .o_data(data2), .o_cim_start(cs_o[2]), .o_done(done_o[2])
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  function automatic logic [7:0] elem(input int k);
    return 8'(k * 37 + (k / 256) * 91 + 11);
  endfunction

  function automatic int beats(input int d);
    int rows;
    rows = (IS[d] > XB) ? XB : IS[d];
    return (rows + LN[d] - 1) / LN[d];
  endfunction

  function automatic logic [31:0] exp_data(input int d, input int addr, input int len);
    logic [31:0] r;
    int row, tiles;
    r = '0;
    tiles = (IS[d] + XB - 1) / XB;
    for (int t = 0; t < tiles; t++)
      for (int l = 0; l < LN[d]; l++) begin
        row = t * XB + addr + l;
        if (row < IS[d] && row < len) r[(t*LN[d]+l)*8 +: 8] = elem(row);
      end
    return r;
  endfunction

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  // Transaction model: active flag, waiting-for-CIM-before-first-write flag,
  // beats written, and the completion pulse.
  bit m_act [3];
  bit m_hold [3];
  int m_wr [3];
  bit m_done [3];
  int m_len [3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst) begin
        m_act[d] = 0; m_hold[d] = 0; m_wr[d] = 0; m_done[d] = 0;
      end else if (m_done[d]) begin
        m_done[d] = 0;
      end else if (!m_act[d]) begin
        if (start_i[d]) begin
          m_act[d]  = 1;
          m_hold[d] = cim_i[d];
          m_wr[d]   = 0;
          m_len[d]  = (int'(len_i[d]) == 0 || int'(len_i[d]) > IS[d]) ? IS[d] : int'(len_i[d]);
        end
      end else if (m_hold[d]) begin
        if (!cim_i[d]) m_hold[d] = 0;
      end else if (m_wr[d] < beats(d)) begin
        if (!cim_i[d]) m_wr[d]++;
      end else if (!fb_i[d]) begin
        m_act[d]  = 0;
        m_done[d] = 1;
      end
    end
  end

  int wr_cnt [3];
  int done_cnt [3];
  int base [3];
  int st_rel [3];
  int dn_rel [3];
  logic [31:0] s_d0_a0, s_d0_a200, s_d1_a8, s_d1_a12, s_d2_a42, s_d2_a44;

  // Single compare process: every output of every DUT, every cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      bit ld;
      if (!rst) begin
        chk(d, "rst_busy", busy_o[d], 0);
        chk(d, "rst_we", we_o[d], 0);
        chk(d, "rst_addr", addr_o[d], 0);
        chk(d, "rst_start", cs_o[d], 0);
        chk(d, "rst_done", done_o[d], 0);
        chk(d, "rst_data", data_o[d], 0);
      end else begin
        ld = m_act[d] && !m_hold[d] && (m_wr[d] < beats(d));
        chk(d, "busy", busy_o[d], m_act[d]);
        chk(d, "we", we_o[d], ld && !cim_i[d]);
        chk(d, "cim_start", cs_o[d], m_act[d] && (m_wr[d] == beats(d)) && !fb_i[d]);
        chk(d, "done", done_o[d], m_done[d]);
        if (ld) chk(d, "addr", addr_o[d], 32'(m_wr[d] * LN[d]));
        if (ld && !cim_i[d]) chk(d, "data", data_o[d], exp_data(d, m_wr[d] * LN[d], m_len[d]));
      end
      if (we_o[d]) wr_cnt[d]++;
      if (cs_o[d]) st_rel[d] = cyc - base[d];
      if (done_o[d]) begin done_cnt[d]++; dn_rel[d] = cyc - base[d]; end
    end
    if (we_o[0] && addr_o[0] == 8'd0)   s_d0_a0   = data_o[0];
    if (we_o[0] && addr_o[0] == 8'd200) s_d0_a200 = data_o[0];
    if (we_o[1] && addr_o[1] == 8'd8)   s_d1_a8   = data_o[1];
    if (we_o[1] && addr_o[1] == 8'd12)  s_d1_a12  = data_o[1];
    if (we_o[2] && addr_o[2] == 8'd42)  s_d2_a42  = data_o[2];
    if (we_o[2] && addr_o[2] == 8'd44)  s_d2_a44  = data_o[2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer on DUT d with busy windows given in cycles relative to start.
  task automatic run(input int d, input int len, input int cb_lo, input int cb_hi,
                     input int fb_lo, input int fb_hi, input int xs, input int probe,
                     input int exp_wr, input int exp_st, input int exp_dn);
    int w0, n0;
    bit seen;
    w0 = wr_cnt[d]; n0 = done_cnt[d]; base[d] = cyc; seen = 0;
    st_rel[d] = -1; dn_rel[d] = -1;
    len_i[d] = 9'(len);
    for (int c = 0; c < 400 && !seen; c++) begin
      start_i[d] = (c == 0) || (c == xs);
      cim_i[d]   = (c >= cb_lo) && (c <= cb_hi);
      fb_i[d]    = (c >= fb_lo) && (c <= fb_hi);
      if (c == probe) begin
        #1;
        chk(d, "stall_we", we_o[d], 0);
        chk(d, "stall_addr", addr_o[d], 17);
      end
      tick();
      seen = (done_cnt[d] != n0);
    end
    start_i[d] = 0; cim_i[d] = 0; fb_i[d] = 0;
    chk(d, "done_seen", seen, 1);
    chk(d, "writes", wr_cnt[d] - w0, exp_wr);
    chk(d, "start_lat", st_rel[d], exp_st);
    chk(d, "done_lat", dn_rel[d], exp_dn);
  endtask

  initial begin
    int n0;
    for (int d = 0; d < 3; d++) begin
      start_i[d] = 0; cim_i[d] = 0; fb_i[d] = 0; len_i[d] = '0;
      wr_cnt[d] = 0; done_cnt[d] = 0; base[d] = 0;
    end
    for (int k = 0; k < 201; k++) d201[k*8 +: 8] = elem(k);
    for (int k = 0; k < 300; k++) d300[k*8 +: 8] = elem(k);

    // Reset state.
    rst = 1'b0;
    repeat (3) tick();
    chk(0, "reset_busy", busy_o[0], 0);
    chk(0, "reset_addr", addr_o[0], 0);
    rst = 1'b1;
    tick();

    // Full-length uncontended transfer; a start during DONE is ignored.
    s_d0_a0 = 32'hDEADBEEF; s_d0_a200 = 32'hDEADBEEF;
    run(0, 0, -1, -1, -1, -1, 203, -1, 201, 202, 203);
    chk(0, "pin_a0", s_d0_a0, 32'h0000000B);
    chk(0, "pin_a200", s_d0_a200, 32'h000000F3);
    tick();

    // CIM stall for three cycles during beat 17, short length 100.
    run(0, 100, 18, 20, -1, -1, -1, 19, 201, 205, 206);

    // CIM busy at start, function busy throughout the load and 5 cycles past
    // the last beat, a second start while busy, over-range length.
    run(0, 255, 0, 2, 0, 209, 50, -1, 201, 210, 211);

    // Reset during beat 50 aborts without a completion pulse.
    n0 = done_cnt[0];
    len_i[0] = '0;
    for (int c = 0; c < 51; c++) begin
      start_i[0] = (c == 0);
      tick();
    end
    rst = 1'b0;
    #1;
    chk(0, "abort_we", we_o[0], 0);
    chk(0, "abort_busy", busy_o[0], 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk(0, "abort_no_done", done_cnt[0] - n0, 0);
    run(0, 0, -1, -1, -1, -1, -1, -1, 201, 202, 203);

    // Four lanes with length 10.
    s_d1_a8 = 32'hDEADBEEF; s_d1_a12 = 32'hDEADBEEF;
    run(1, 10, -1, -1, -1, -1, -1, -1, 51, 52, 53);
    chk(1, "pin_a8", s_d1_a8, 32'h00005833);
    chk(1, "pin_a12", s_d1_a12, 32'h00000000);

    // Two tiles, two lanes.
    s_d2_a42 = 32'hDEADBEEF; s_d2_a44 = 32'hDEADBEEF;
    run(2, 0, -1, -1, -1, -1, -1, -1, 128, 129, 130);
    chk(2, "pin_a42", s_d2_a42, 32'h9D78421D);
    chk(2, "pin_a44", s_d2_a44, 32'h00008C67);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
